// File: rtl/mem_responder.sv
// mem_responder: memory-side slave for valid/ready memory requests.
// Accepts one request at a time, holds it for LATENCY cycles, then performs
// a word read or a byte-masked write on an internal word array and presents
// the result on a response channel held until the initiator accepts it.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   req_valid  initiator has a request
//   req_ready  responder can accept a request (high only in IDLE)
//   req_addr   byte address, bits [1:0] ignored
//   req_wen    1 = write, 0 = read
//   req_wdata  write data
//   req_wmask  byte enables for writes, bit i = byte i
//   rsp_valid  response available
//   rsp_ready  initiator accepts the response
//   rsp_rdata  read data; 0 for writes and errors
//   rsp_err    address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH)
module mem_responder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int unsigned       LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BYTES    = DATA_W / 8;
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned SPAN_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
  // One bit wider than the address so 4*DEPTH cannot overflow the compare.
  localparam logic [SPAN_W-1:0] SPAN     = SPAN_W'(64'(DEPTH) * 64'(BYTES));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Decoded request held for the duration of one operation.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              err;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [BYTES-1:0]  wmask;
  } op_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  op_t               op, op_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              err_nxt;
  logic              req_ready_nxt;
  logic              rsp_valid_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] offset_c;
  op_t               in_op_c;
  op_t               cur_op_c;
  logic              commit_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] rd_word_c;

  // Decode the incoming request; addresses below BASE wrap high and err.
  assign offset_c        = req_addr - BASE_ADDR;
  assign in_op_c.idx     = offset_c[IDX_W+1:2];
  assign in_op_c.err     = ({1'b0, offset_c} >= SPAN);
  assign in_op_c.wen     = req_wen;
  assign in_op_c.wdata   = req_wdata;
  assign in_op_c.wmask   = req_wmask;

  // With LATENCY==0 the commit edge is the accepting edge, so the operation
  // must come straight from the request port rather than the held copy.
  assign cur_op_c  = (state == S_IDLE) ? in_op_c : op;
  assign rd_word_c = mem[cur_op_c.idx];
  assign mem_we_c  = rst & commit_c & cur_op_c.wen & ~cur_op_c.err;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op        <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      op        <= op_nxt;
      rsp_rdata <= rdata_nxt;
      rsp_err   <= err_nxt;
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
    end
  end

  // Next-state, counter and response data.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op;
    rdata_nxt = rsp_rdata;
    err_nxt   = rsp_err;
    commit_c  = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_nxt = in_op_c;
          if (LATENCY == 0) begin
            state_nxt = S_RESP;
            commit_c  = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_RESP;
          commit_c  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Response payload is captured on the edge entering RESP only.
    if (commit_c) begin
      err_nxt   = cur_op_c.err;
      rdata_nxt = (!cur_op_c.wen && !cur_op_c.err) ? rd_word_c : '0;
    end

    req_ready_nxt = (state_nxt == S_IDLE);
    rsp_valid_nxt = (state_nxt == S_RESP);
  end

  // Word array, not reset; byte-masked write on the commit edge.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < int'(BYTES); i++) begin
        if (cur_op_c.wmask[i]) begin
          mem[cur_op_c.idx][8*i +: 8] <= cur_op_c.wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 0, 15) on one clock.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic        req_wen   [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wmask [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_wen(req_wen[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_wen(req_wen[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  mem_responder #(.LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
    .req_wen(req_wen[2]), .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction with rsp_ready held high. n counts edges from
  // the accepting edge (counted as 1) to the edge raising rsp_valid.
  task automatic do_op(input int k, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] m,
                       output logic [31:0] rd, output logic e, output int n);
    int t;
    @(negedge clk);
    req_valid[k] = 1'b1; req_addr[k] = a; req_wen[k] = w;
    req_wdata[k] = d; req_wmask[k] = m; rsp_ready[k] = 1'b1;
    t = 0;
    while (!req_ready[k] && t < 50) begin @(negedge clk); t++; end
    if (!req_ready[k]) chk("req_ready_timeout", 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req_valid[k] = 1'b0;
    while (!rsp_valid[k] && n < 40) begin @(posedge clk); n++; @(negedge clk); end
    rd = rsp_rdata[k];
    e  = rsp_err[k];
    @(negedge clk);
    chk("valid_drop_after_hs", 32'(rsp_valid[k]), 32'd0);
    chk("ready_after_hs", 32'(req_ready[k]), 32'd1);
  endtask

  // Hold req_valid and rsp_ready high; acceptances must be LATENCY+2 apart.
  task automatic throughput(input int k, input int lat);
    int acc [3];
    int na;
    int t;
    na = 0;
    @(negedge clk);
    req_valid[k] = 1'b1; req_addr[k] = 32'h7FFF_FFFC; req_wen[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    for (int i = 0; i < 100 && na < 3; i++) begin
      if (req_ready[k]) begin acc[na] = cyc + 1; na++; end
      @(negedge clk);
    end
    req_valid[k] = 1'b0;
    chk("thr_accept_count", 32'(na), 32'd3);
    if (na == 3) begin
      chk("thr_period_a", 32'(acc[1] - acc[0]), 32'(lat + 2));
      chk("thr_period_b", 32'(acc[2] - acc[1]), 32'(lat + 2));
    end
    t = 0;
    while (!req_ready[k] && t < 50) begin @(negedge clk); t++; end
    chk("thr_idle_again", 32'(req_ready[k]), 32'd1);
  endtask

  logic [31:0] rd;
  logic        e;
  int          n;
  int          t;

  initial begin
    vecs[0]  = '{32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{32'h8000_0010, 1'b1, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
    vecs[3]  = '{32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{32'h7FFF_FFFC, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[5]  = '{32'h8000_1000, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[6]  = '{32'h8000_0000, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    vecs[7]  = '{32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[8]  = '{32'h8000_0000, 1'b1, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[9]  = '{32'h8000_0000, 1'b0, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{32'h8000_0013, 1'b0, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
    vecs[11] = '{32'h8000_0FFC, 1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0};
    vecs[12] = '{32'h8000_0FFC, 1'b1, 32'h5A5A_5A5A, 4'hA, 32'h0,         1'b0};
    vecs[13] = '{32'h8000_0FFE, 1'b0, 32'h0,         4'h0, 32'h5AA5_5AA5, 1'b0};

    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; req_wen[k] = 1'b0;
      req_wdata[k] = '0; req_wmask[k] = '0; rsp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_req_ready", 32'(req_ready[k]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[k], 32'd0);
      chk("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
    end

    // Directed vectors on the LATENCY=1 instance.
    for (int i = 0; i < NVEC; i++) begin
      do_op(0, vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].wmask, rd, e, n);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(n), 32'd2);
    end

    // Backpressure: response held stable and new requests ignored.
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0010; req_wen[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    t = 0;
    while (!rsp_valid[0] && t < 20) begin
      @(negedge clk); t++;
      // After acceptance, present a conflicting write that must be ignored.
      req_wen[0] = 1'b1; req_wdata[0] = 32'h0; req_wmask[0] = 4'hF;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata[0], 32'hDE22_BE44);
      chk("bp_rsp_err", 32'(rsp_err[0]), 32'd0);
      chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_valid_after_hs", 32'(rsp_valid[0]), 32'd0);
    chk("bp_ready_after_hs", 32'(req_ready[0]), 32'd1);
    do_op(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, rd, e, n);
    chk("bp_data_kept", rd, 32'hDE22_BE44);

    // Asynchronous reset between edges while a response is pending.
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0000; req_wen[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    t = 0;
    while (!rsp_valid[0] && t < 20) begin @(negedge clk); t++; req_valid[0] = 1'b0; end
    req_valid[0] = 1'b0;
    chk("arst_pre_rdata", rsp_rdata[0], 32'hCAFE_F00D);
    #1 rst = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("arst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("arst_rsp_rdata", rsp_rdata[0], 32'd0);
    #1 rst = 1'b1;

    // Reset during WAIT aborts a write that has not committed.
    do_op(0, 32'h8000_0020, 1'b1, 32'h1111_1111, 4'hF, rd, e, n);
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0020; req_wen[0] = 1'b1;
    req_wdata[0] = 32'h2222_2222; req_wmask[0] = 4'hF; rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("abort_in_wait", 32'(req_ready[0]), 32'd0);
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    do_op(0, 32'h8000_0020, 1'b0, 32'h0, 4'h0, rd, e, n);
    chk("abort_no_write", rd, 32'h1111_1111);

    // Latency extremes.
    do_op(1, 32'h8000_0040, 1'b1, 32'h0102_0304, 4'hF, rd, e, n);
    chk("l0_write_latency", 32'(n), 32'd1);
    do_op(1, 32'h8000_0040, 1'b0, 32'h0, 4'h0, rd, e, n);
    chk("l0_read_latency", 32'(n), 32'd1);
    chk("l0_read_data", rd, 32'h0102_0304);
    do_op(2, 32'h8000_0044, 1'b1, 32'hA0B0_C0D0, 4'hF, rd, e, n);
    chk("l15_write_latency", 32'(n), 32'd16);
    do_op(2, 32'h8000_0044, 1'b0, 32'h0, 4'h0, rd, e, n);
    chk("l15_read_latency", 32'(n), 32'd16);
    chk("l15_read_data", rd, 32'hA0B0_C0D0);

    // Back-to-back throughput.
    throughput(1, 0);
    throughput(0, 1);
    throughput(2, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's valid/ready memory requests: the slave end that the IFU fetch port and the LSU data port initiate into.
- Accepts one request at a time and holds it for a programmable latency.
- Performs a word read or a byte-masked write on an internal word array.
- Returns a response on a separate valid/ready channel that is held until the initiator accepts it.

Parameters:
- ADDR_W, 32, request address width.
- DEPTH, 1024, number of 32-bit words in the internal array (power of two).
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0.
- LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 0..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  initiator has a request.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_W  byte address; bits [1:0] are ignored.
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- req_wmask  in  4  byte enables for writes, bit i = byte i.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH).

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; delay counter = 0.
  - Array contents are not reset.
  - Reset mid-operation aborts the request: no array write occurs unless the write already committed on an earlier edge.
- States:
  - IDLE: req_ready=1.
  - WAIT: counting latency; req_ready=0.
  - RESP: rsp_valid=1, req_ready=0.
- Acceptance: a request is accepted on an edge where req_valid & req_ready.
  - Latch addr, wen, wdata and wmask.
  - Compute index = (addr-BASE_ADDR)>>2 and err = out-of-range (unsigned compare; below BASE wraps to a large value and errs).
- Transitions:
  - IDLE -> RESP on acceptance if LATENCY==0.
  - IDLE -> WAIT on acceptance otherwise, with counter = LATENCY-1.
  - WAIT: counter decrements each cycle; at counter==0 -> RESP on the next edge.
  - So rsp_valid rises exactly LATENCY+1 edges after the accepting edge (LATENCY=0: first cycle after acceptance).
- Operation commit happens on the edge entering RESP:
  - Write with err=0: for each i with wmask[i]=1, byte i of mem[index] = wdata byte i. wmask=0 writes nothing. rsp_rdata=0.
  - Read with err=0: rsp_rdata = mem[index] as it was before any same-edge write (only one op is in flight, so there is no conflict).
  - err=1: no array access; rsp_rdata=0; rsp_err=1.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready; then -> IDLE and rsp_valid=0 next cycle.
  - rsp_valid does not depend combinationally on rsp_ready.
- No combinational path from rsp_ready to req_ready: a new request cannot be accepted in the cycle the response handshakes. Back-to-back throughput is one op per LATENCY+2 cycles.
- req_* signals are ignored while not in IDLE. The initiator must hold req_* stable while req_valid=1 and req_ready=0.
- rsp_rdata and rsp_err hold their last values in IDLE/WAIT. Only rsp_valid qualifies them.

Test Plan:
- Reset, LATENCY=1: rst low then high -> req_ready=1, rsp_valid=0, rsp_rdata=0. Pulsing rst low asynchronously between edges forces the same outputs immediately.
- Write 32'hDEAD_BEEF mask 4'hF at 32'h8000_0010, then read the same address -> read response rsp_rdata=32'hDEAD_BEEF, rsp_err=0; rsp_valid rises 2 edges after acceptance.
- Partial write 32'h1122_3344 mask 4'b0101 over 32'hDEAD_BEEF at 32'h8000_0010 -> read returns 32'hDE22_BE44.
- Out of range: read at 32'h7FFF_FFFC and at 32'h8000_1000 (DEPTH=1024) -> rsp_err=1, rsp_rdata=0. A following in-range read still returns the stored data, so the array was unaffected.
- Backpressure: hold rsp_ready=0 for 5 cycles with rsp_valid=1 -> rsp_valid/rsp_rdata/rsp_err stable, req_ready=0 and new req_valid ignored. Asserting rsp_ready gives a handshake, then req_ready=1 the next cycle.
- Latency sweep LATENCY=0 and 15 -> rsp_valid first high 1 and 16 cycles after acceptance respectively. With req_valid and rsp_ready both held at 1, a request is accepted every LATENCY+2 cycles.
